// File: rtl/mux_scan_reg.sv
// CHANNELS:1 word multiplexer with a registered valid/ready output port.
// Direct mode emits one selected channel; scan mode walks every channel once.
module mux_scan_lane #(
    parameter int WIDTH = 8,
    parameter int SEL_W = 3,
    parameter int IDX   = 0
) (
    input  logic [SEL_W-1:0] sel,
    input  logic [WIDTH-1:0] word,
    output logic [WIDTH-1:0] gated
);
    localparam logic [SEL_W-1:0] ME = SEL_W'(IDX);

    assign gated = (sel == ME) ? word : '0;
endmodule

module mux_scan_reg #(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 8,
    parameter int SEL_W    = 3
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start,
    input  logic                      mode,
    input  logic [SEL_W-1:0]          sel_in,
    input  logic [CHANNELS*WIDTH-1:0] in_bus,
    input  logic                      out_ready,
    output logic                      out_valid,
    output logic [WIDTH-1:0]          out_data,
    output logic [SEL_W-1:0]          out_sel,
    output logic                      busy,
    output logic                      done,
    output logic                      err
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_EMIT = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [SEL_W:0]   NCH  = (SEL_W+1)'(CHANNELS);
    localparam logic [SEL_W-1:0] LAST = SEL_W'(CHANNELS - 1);

    logic [1:0]                         state;
    logic                               mode_q;
    logic [SEL_W-1:0]                   cnt;
    logic [SEL_W-1:0]                   nxt;
    logic [SEL_W-1:0]                   fetch_sel;
    logic [WIDTH-1:0]                   fetch_data;
    logic [CHANNELS-1:0][WIDTH-1:0]     gated;
    logic                               sel_ok;
    logic                               xfer;
    logic                               last;

    assign sel_ok = {1'b0, sel_in} < NCH;
    assign xfer   = out_valid && out_ready;
    assign last   = mode_q ? (cnt == LAST) : (cnt == '0);
    // Wrap on the real channel count so non-power-of-2 CHANNELS never emits a ghost index.
    assign nxt       = (out_sel == LAST) ? '0 : out_sel + SEL_W'(1);
    assign fetch_sel = (state == S_IDLE) ? sel_in : nxt;

    for (genvar k = 0; k < CHANNELS; k++) begin : g_lane
        mux_scan_lane #(.WIDTH(WIDTH), .SEL_W(SEL_W), .IDX(k)) u_lane (
            .sel   (fetch_sel),
            .word  (in_bus[k*WIDTH +: WIDTH]),
            .gated (gated[k])
        );
    end

    always_comb begin
        fetch_data = '0;
        for (int k = 0; k < CHANNELS; k++) fetch_data = fetch_data | gated[k];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= S_IDLE;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sel   <= '0;
            cnt       <= '0;
            mode_q    <= 1'b0;
            err       <= 1'b0;
        end else begin
            err <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        if (sel_ok) begin
                            out_data  <= fetch_data;
                            out_sel   <= sel_in;
                            out_valid <= 1'b1;
                            mode_q    <= mode;
                            cnt       <= '0;
                            state     <= S_EMIT;
                        end else begin
                            err <= 1'b1;
                        end
                    end
                end
                S_EMIT: begin
                    // Without a transfer the output word stays frozen regardless of in_bus.
                    if (xfer) begin
                        if (last) begin
                            out_valid <= 1'b0;
                            state     <= S_DONE;
                        end else begin
                            out_sel  <= nxt;
                            out_data <= fetch_data;
                            cnt      <= cnt + SEL_W'(1);
                        end
                    end
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    assign busy = (state == S_EMIT) || (state == S_DONE);
    assign done = (state == S_DONE);
endmodule

// File: tb/tb_mux_scan_reg.sv
// Randomized bench for mux_scan_reg: an 8-channel and a 5-channel instance
// checked against an index/word sequence model derived from the channel rules.
module tb_mux_scan_reg;
    logic        clk = 1'b0;
    logic        reset, start8, start5, mode, out_ready;
    logic [2:0]  sel_in;
    logic [63:0] bus8;
    logic [39:0] bus5;
    logic        v8, b8, dn8, e8, v5, b5, dn5, e5;
    logic [7:0]  d8, d5;
    logic [2:0]  s8, s5;

    bit          use5;
    logic        ov, obusy, odone, oerr;
    logic [7:0]  od;
    logic [2:0]  os;
    logic [7:0]  pat_base;

    int tests = 0;
    int fails = 0;

    logic [2:0] obs_sel[$];
    logic [2:0] exp_sel[$];
    logic [7:0] obs_data[$];
    logic [7:0] exp_data[$];
    int hold_err, done_cnt, done_cyc, last_xfer_cyc, first_valid_cyc, err_seen, seq_bad, busy_after;
    bit timeout;

    always #5 clk = ~clk;

    mux_scan_reg #(.WIDTH(8), .CHANNELS(8), .SEL_W(3)) dut8 (
        .clk(clk), .reset(reset), .start(start8), .mode(mode), .sel_in(sel_in),
        .in_bus(bus8), .out_ready(out_ready), .out_valid(v8), .out_data(d8),
        .out_sel(s8), .busy(b8), .done(dn8), .err(e8)
    );

    mux_scan_reg #(.WIDTH(8), .CHANNELS(5), .SEL_W(3)) dut5 (
        .clk(clk), .reset(reset), .start(start5), .mode(mode), .sel_in(sel_in),
        .in_bus(bus5), .out_ready(out_ready), .out_valid(v5), .out_data(d5),
        .out_sel(s5), .busy(b5), .done(dn5), .err(e5)
    );

    always_comb begin
        if (use5) begin
            ov = v5; od = d5; os = s5; obusy = b5; odone = dn5; oerr = e5;
        end else begin
            ov = v8; od = d8; os = s8; obusy = b8; odone = dn8; oerr = e8;
        end
    end

    function automatic logic [7:0] word_of(input int idx);
        return use5 ? bus5[idx*8 +: 8] : bus8[idx*8 +: 8];
    endfunction

    task automatic set_bus(input bit rnd);
        for (int k = 0; k < 8; k++) bus8[k*8 +: 8] = rnd ? 8'($urandom) : pat_base + 8'(k);
        for (int k = 0; k < 5; k++) bus5[k*8 +: 8] = rnd ? 8'($urandom) : pat_base + 8'(k);
    endtask

    // Drives one request from a negedge and records what the DUT hands over.
    // Model: word i is channel (sel+i) mod CHANNELS, sampled from in_bus at the
    // edge where it is loaded (start edge, or the transfer edge of word i-1).
    task automatic run_txn(input bit m, input int sel, input int pct, input int stall_at,
                           input int stall_len, input bit toggle, input bit poke, input int abort_at);
        int n, ch, loaded, stalled, cyc;
        logic pv, prdy, rdy;
        logic [7:0] pd;
        logic [2:0] ps;
        ch = use5 ? 5 : 8;
        n  = m ? ch : 1;
        obs_sel.delete(); obs_data.delete(); exp_sel.delete(); exp_data.delete();
        hold_err = 0; done_cnt = 0; done_cyc = -1; last_xfer_cyc = -1; first_valid_cyc = -1;
        err_seen = 0; busy_after = -1; timeout = 1'b1; stalled = 0;
        set_bus(1'b0);
        mode = m; sel_in = 3'(sel); out_ready = 1'b0; prdy = 1'b0;
        if (use5) start5 = 1'b1; else start8 = 1'b1;
        exp_sel.push_back(3'(sel)); exp_data.push_back(word_of(sel));
        loaded = 1;
        pv = 1'b0; pd = '0; ps = '0;
        for (cyc = 1; cyc < 300; cyc++) begin
            @(negedge clk);
            start8 = 1'b0; start5 = 1'b0;
            mode = 1'($urandom); sel_in = 3'($urandom);
            if (ov && first_valid_cyc < 0) first_valid_cyc = cyc;
            if (pv && !prdy && (od !== pd || os !== ps)) hold_err++;
            if (oerr) err_seen++;
            if (odone) begin
                done_cnt++;
                if (done_cyc < 0) done_cyc = cyc;
            end
            if (done_cyc >= 0 && cyc == done_cyc + 1) begin
                busy_after = int'(obusy); timeout = 1'b0; break;
            end
            if (abort_at >= 0 && obs_data.size() == abort_at) begin
                timeout = 1'b0; break;
            end
            pv = ov; pd = od; ps = os;
            rdy = (obs_data.size() == stall_at && stalled < stall_len) ? 1'b0
                                                                      : ($urandom_range(99) < pct);
            if (!rdy && ov && obs_data.size() == stall_at) stalled++;
            out_ready = rdy; prdy = rdy;
            set_bus(toggle && !rdy);
            if (ov && rdy) begin
                obs_sel.push_back(os); obs_data.push_back(od);
                if (loaded < n) begin
                    exp_sel.push_back(3'((sel + loaded) % ch));
                    exp_data.push_back(word_of((sel + loaded) % ch));
                    loaded++;
                end else begin
                    last_xfer_cyc = cyc;
                end
            end
            if (poke && ov) begin
                if (use5) start5 = 1'b1; else start8 = 1'b1;
            end
        end
        start8 = 1'b0; start5 = 1'b0;
        seq_bad = (obs_data.size() == exp_data.size()) ? 0 : 1;
        foreach (exp_data[i])
            if (i >= obs_data.size() || obs_data[i] !== exp_data[i] || obs_sel[i] !== exp_sel[i])
                seq_bad++;
    endtask

    task automatic test_reset();
        reset = 1'b1; start8 = 1'b0; start5 = 1'b0; mode = 1'b0; sel_in = '0; out_ready = 1'b0;
        use5 = 1'b0; pat_base = 8'h10; set_bus(1'b0);
        repeat (3) @(negedge clk);
        tests++;
        if ({v8, d8, s8, b8, dn8, e8} !== 15'd0)
            $display("FAIL reset_dut8: got %b want 0", {v8, d8, s8, b8, dn8, e8});
        tests++;
        if ({v5, d5, s5, b5, dn5, e5} !== 15'd0)
            $display("FAIL reset_dut5: got %b want 0", {v5, d5, s5, b5, dn5, e5});
        if ({v8, d8, s8, b8, dn8, e8} !== 15'd0) fails++;
        if ({v5, d5, s5, b5, dn5, e5} !== 15'd0) fails++;
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_direct();
        use5 = 1'b0; pat_base = 8'h10;
        run_txn(1'b0, 5, 100, -1, 0, 1'b0, 1'b0, -1);
        tests++;
        if (obs_data.size() != 1 || obs_data[0] !== 8'h15 || obs_sel[0] !== 3'd5) begin
            fails++;
            $display("FAIL direct_word: got %0d words first %h/%0d want 1 word 15/5",
                     obs_data.size(), obs_data.size() ? obs_data[0] : 8'hxx,
                     obs_sel.size() ? obs_sel[0] : 3'bx);
        end
        tests++;
        if (first_valid_cyc != 1) begin
            fails++; $display("FAIL direct_latency: got %0d want 1", first_valid_cyc);
        end
        tests++;
        if (done_cyc != 2 || done_cnt != 1 || busy_after != 0 || timeout) begin
            fails++;
            $display("FAIL direct_done: done at %0d x%0d busy_after %0d to %0d want at 2 x1 busy 0",
                     done_cyc, done_cnt, busy_after, timeout);
        end
    endtask

    task automatic test_scan_wrap();
        int bad;
        use5 = 1'b0; pat_base = 8'h10;
        run_txn(1'b1, 6, 100, -1, 0, 1'b0, 1'b0, -1);
        bad = (obs_data.size() == 8) ? 0 : 1;
        foreach (obs_data[i]) if (obs_data[i] !== 8'h10 + 8'((6 + i) % 8)) bad++;
        tests++;
        if (bad != 0 || seq_bad != 0) begin
            fails++; $display("FAIL scan_wrap_seq: %0d bad words model %0d, got %0d words want 8",
                              bad, seq_bad, obs_data.size());
        end
        tests++;
        if (done_cyc != last_xfer_cyc + 1 || done_cyc != 9 || done_cnt != 1) begin
            fails++; $display("FAIL scan_wrap_done: done at %0d x%0d want 9 x1", done_cyc, done_cnt);
        end
    endtask

    task automatic test_stall();
        use5 = 1'b0; pat_base = 8'h10;
        run_txn(1'b1, 0, 100, 2, 3, 1'b1, 1'b0, -1);
        tests++;
        if (obs_data.size() != 8 || obs_data[2] !== 8'h12 || seq_bad != 0) begin
            fails++; $display("FAIL stall_seq: got %0d words word2 %h bad %0d want 8 words word2 12 bad 0",
                              obs_data.size(), obs_data.size() > 2 ? obs_data[2] : 8'hxx, seq_bad);
        end
        tests++;
        if (hold_err != 0) begin
            fails++; $display("FAIL stall_hold: got %0d changes while stalled want 0", hold_err);
        end
    endtask

    task automatic test_ch5();
        logic [2:0] want [5];
        int bad;
        want = '{3'd3, 3'd4, 3'd0, 3'd1, 3'd2};
        use5 = 1'b1; pat_base = 8'hA0; set_bus(1'b0);
        for (int s = 5; s < 8; s++) begin
            sel_in = 3'(s); mode = 1'b1; start5 = 1'b1;
            @(negedge clk);
            start5 = 1'b0;
            tests++;
            if (e5 !== 1'b1 || v5 !== 1'b0 || b5 !== 1'b0) begin
                fails++; $display("FAIL ch5_err_sel%0d: err %b valid %b busy %b want 1 0 0", s, e5, v5, b5);
            end
            @(negedge clk);
            tests++;
            if (e5 !== 1'b0 || v5 !== 1'b0) begin
                fails++; $display("FAIL ch5_err_pulse_sel%0d: err %b valid %b want 0 0", s, e5, v5);
            end
        end
        run_txn(1'b1, 3, 100, -1, 0, 1'b0, 1'b0, -1);
        bad = (obs_sel.size() == 5) ? 0 : 1;
        foreach (obs_sel[i]) if (i < 5 && obs_sel[i] !== want[i]) bad++;
        tests++;
        if (bad != 0 || seq_bad != 0 || obs_data[0] !== 8'hA3) begin
            fails++; $display("FAIL ch5_wrap: %0d bad indices model %0d got %0d words want 3,4,0,1,2",
                              bad, seq_bad, obs_sel.size());
        end
        use5 = 1'b0;
    endtask

    task automatic test_back_to_back();
        use5 = 1'b0; pat_base = 8'h30;
        run_txn(1'b1, int'($urandom_range(7)), 60, -1, 0, 1'b1, 1'b1, -1);
        tests++;
        if (seq_bad != 0 || obs_data.size() != 8 || hold_err != 0) begin
            fails++; $display("FAIL busy_start_seq: got %0d words bad %0d hold %0d want 8 0 0",
                              obs_data.size(), seq_bad, hold_err);
        end
        tests++;
        if (done_cnt != 1 || err_seen != 0 || busy_after != 0 || timeout) begin
            fails++; $display("FAIL busy_start_done: done x%0d err x%0d busy_after %0d want 1 0 0",
                              done_cnt, err_seen, busy_after);
        end
    endtask

    task automatic test_random();
        for (int it = 0; it < 8; it++) begin
            bit m;
            int ch;
            use5 = it[0];
            ch = use5 ? 5 : 8;
            pat_base = 8'($urandom);
            m = 1'($urandom);
            run_txn(m, int'($urandom_range(ch - 1)), int'($urandom_range(100, 30)), -1, 0,
                    1'($urandom), 1'b0, -1);
            tests++;
            if (seq_bad != 0 || hold_err != 0) begin
                fails++; $display("FAIL random_seq_%0d: bad %0d hold %0d words %0d want 0 0 %0d",
                                  it, seq_bad, hold_err, obs_data.size(), m ? ch : 1);
            end
            tests++;
            if (done_cnt != 1 || done_cyc != last_xfer_cyc + 1 || timeout) begin
                fails++; $display("FAIL random_done_%0d: done at %0d x%0d last xfer %0d", it,
                                  done_cyc, done_cnt, last_xfer_cyc);
            end
        end
        use5 = 1'b0;
    endtask

    task automatic test_reset_mid();
        int stray;
        use5 = 1'b0; pat_base = 8'h10;
        run_txn(1'b1, int'($urandom_range(7)), 100, -1, 0, 1'b0, 1'b0, 4);
        tests++;
        if (obs_data.size() != 4 || timeout || v8 !== 1'b1) begin
            fails++; $display("FAIL reset_mid_setup: got %0d words valid %b want 4 1", obs_data.size(), v8);
        end
        #2 reset = 1'b1;
        #1;
        tests++;
        if ({v8, d8, s8, b8, dn8, e8} !== 15'd0) begin
            fails++; $display("FAIL reset_mid_async: got %b want 0", {v8, d8, s8, b8, dn8, e8});
        end
        @(negedge clk);
        reset = 1'b0;
        stray = 0;
        repeat (3) begin
            @(negedge clk);
            if (dn8 || v8 || b8) stray++;
        end
        tests++;
        if (stray != 0) begin
            fails++; $display("FAIL reset_mid_nodone: got %0d active cycles want 0", stray);
        end
        run_txn(1'b0, 2, 100, -1, 0, 1'b0, 1'b0, -1);
        tests++;
        if (seq_bad != 0 || obs_data.size() != 1 || obs_data[0] !== 8'h12 || done_cnt != 1) begin
            fails++; $display("FAIL reset_mid_restart: got %0d words bad %0d done x%0d want 1 0 1",
                              obs_data.size(), seq_bad, done_cnt);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_direct();
        test_scan_wrap();
        test_stall();
        test_ch5();
        test_back_to_back();
        test_random();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
